// File: rtl/logic_arb.sv
// logic_arb: two requesters share one bitwise logic unit (AND/OR/XOR/NOT a).
// One operation in flight; round-robin grant on ties; result is held
// until the consumer takes it.
//
// state | meaning
// IDLE  | no result held, a requester may be granted
// RESP  | result held, rsp_valid=1, waiting for rsp_ready
module logic_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant0, grant1;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] result;

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Operand mux and the shared logic unit.
  always_comb begin
    sel_op = grant1 ? req1_op : req0_op;
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
    result = '0;
    case (sel_op)
      2'b00:   result = sel_a & sel_b;
      2'b01:   result = sel_a | sel_b;
      2'b10:   result = sel_a ^ sel_b;
      default: result = ~sel_a;
    endcase
  end

  // Next state and handshake outputs; rst_n gates the readies so nothing is
  // accepted while reset is held, even though IDLE is already forced.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 & rst_n;
        req1_ready = grant1 & rst_n;
        accept     = (grant0 | grant1) & rst_n;
        if (accept) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture result, owner and grant pointer on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_data   <= result;
      rsp_id     <= grant1;
      last_grant <= grant1;
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_logic_arb.sv
// tb_logic_arb: directed stimulus with a response scoreboard for logic_arb.
module tb_logic_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  logic       seen = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] held_data;
  logic       held_id;

  logic_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle with inputs already driven: check grants at the falling edge,
  // record the expected response if a grant is due, then move past the edge.
  task automatic step(input logic e_r0, input logic e_r1, input logic e_rv,
                      input logic [7:0] e_data);
    @(negedge clk);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
    if (e_r0 | e_r1) exp_q.push_back({e_r1, e_data});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each newly presented response, enforce hold-stability
  // under backpressure and the ready protocol every cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      seen <= 1'b0;
      hold <= 1'b0;
    end else begin
      if (req0_ready && !req0_valid) chk("ready0_without_valid", 1, 0);
      if (req1_ready && !req1_valid) chk("ready1_without_valid", 1, 0);
      if (req0_ready && req1_ready)  chk("two_readies", 1, 0);
      if (rsp_valid && !seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {23'b0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", {24'b0, rsp_data}, {24'b0, e[7:0]});
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e[8]});
        end
      end else if (rsp_valid && hold) begin
        chk("held_data", {24'b0, rsp_data}, {24'b0, held_data});
        chk("held_id", {31'b0, rsp_id}, {31'b0, held_id});
      end
      seen      <= rsp_valid && !rsp_ready;
      hold      <= rsp_valid && !rsp_ready;
      held_data <= rsp_data;
      held_id   <= rsp_id;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h00; req1_b = 8'h00;
    rsp_ready = 1'b1;

    // Reset values, nothing granted even with both requesters valid.
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", {31'b0, req0_ready}, 0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'b0, rsp_data}, 0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req1_valid = 1'b0;

    // Single request: F0 & 3C = 30.
    step(1, 0, 0, 8'h30);
    req0_valid = 1'b0;
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Ties after reset alternate starting with req0: 01|02=03, FF^0F=F0.
    do_reset();
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'h0F;
    step(1, 0, 0, 8'h03);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hF0);
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h03);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Backpressure: NOT A5 = 5A held 5 cycles with req0 waiting.
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'hA5; req1_b = 8'h77;
    rsp_ready = 1'b0;
    step(0, 1, 0, 8'h5A);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'hFF; req0_b = 8'h0F;
    repeat (5) step(0, 0, 1, 8'h00);
    rsp_ready = 1'b1;
    step(0, 0, 1, 8'h00);

    // Operand change after accept: FF & 0F = 0F stays after a goes to 00.
    step(1, 0, 0, 8'h0F);
    req0_valid = 1'b0; req0_a = 8'h00; rsp_ready = 1'b0;
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    rsp_ready = 1'b1;
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Reset while holding 3C ^ 0F = 33; result dropped, tie then goes to req0.
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'h3C; req1_b = 8'h0F;
    rsp_ready = 1'b0;
    step(0, 1, 0, 8'h33);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("midrst_rsp_data", {24'b0, rsp_data}, 0);
    chk("midrst_rsp_id", {31'b0, rsp_id}, 0);
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'h0F;
    @(negedge clk);
    chk("midrst_req0_ready", {31'b0, req0_ready}, 0);
    chk("midrst_req1_ready", {31'b0, req1_ready}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step(1, 0, 0, 8'h03);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    repeat (2) @(posedge clk);
    chk("pending_responses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
